contador_mod_n: RTL



---
 rtl/contador_pkg.sv | 23 ++
 rtl/dff_nbits_rst.sv | 20 ++
 rtl/contador_mod_n.sv | 129 ++++++++++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared definitions for the modulus-N counter: mode encodings and
// elaboration-time parameter legality checks.
package contador_pkg;

   localparam logic [1:0] MODO_UP   = 2'b00;
   localparam logic [1:0] MODO_DOWN = 2'b01;
   localparam logic [1:0] MODO_STEP = 2'b10;
   localparam logic [1:0] MODO_LOAD = 2'b11;

   // Upper bound keeps 2**BITS representable in a 32-bit int parameter.
   function automatic bit bits_ok(input int bits);
      return (bits >= 1) && (bits <= 30);
   endfunction

   function automatic bit max_ok(input int bits, input int max_val);
      return (max_val >= 0) && (longint'(max_val) < (longint'(1) << bits));
   endfunction

   function automatic bit step_ok(input int step, input int max_val);
      return (step >= 1) && (step <= max_val);
   endfunction

endpackage

// File: rtl/dff_nbits_rst.sv
// N-bit register with synchronous active-high reset and clock enable.
module dff_nbits_rst #(
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/contador_mod_n.sv
// Modulus-N up/down/step counter with parallel load, registered wrap pulse
// (RCO) for cascading, and a registered pulse flagging clamped loads.
module contador_mod_n
   import contador_pkg::*;
#(
   parameter int BITS    = 4,
   parameter int MAX_VAL = 2**BITS - 1,
   parameter int STEP    = 3
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            ENB,
   input  logic [1:0]      MODO,
   input  logic [BITS-1:0] D,
   output logic [BITS-1:0] Q,
   output logic            RCO,
   output logic            LOAD_ERR
);

   if (!bits_ok(BITS)) begin : g_bad_bits
      $fatal(1, "contador_mod_n: BITS=%0d out of range", BITS);
   end
   if (!max_ok(BITS, MAX_VAL)) begin : g_bad_max
      $fatal(1, "contador_mod_n: MAX_VAL=%0d does not fit in BITS=%0d", MAX_VAL, BITS);
   end
   if (!step_ok(STEP, MAX_VAL)) begin : g_bad_step
      $fatal(1, "contador_mod_n: STEP=%0d must lie in 1..MAX_VAL=%0d", STEP, MAX_VAL);
   end

   // One extra bit so Q+M-STEP never overflows before truncation.
   localparam logic [BITS:0] MAX_W  = (BITS+1)'(MAX_VAL);
   localparam logic [BITS:0] MOD_W  = (BITS+1)'(MAX_VAL + 1);
   localparam logic [BITS:0] STEP_W = (BITS+1)'(STEP);
   localparam logic [BITS:0] ONE_W  = (BITS+1)'(1);

   logic [BITS:0]   q_ext_p0;
   logic [BITS:0]   d_ext_p0;
   logic [BITS:0]   sum_p0;
   logic [BITS-1:0] q_next_p0;
   logic            rco_next_p0;
   logic            lerr_next_p0;
   logic [1:0]      pulse_q_p1;

   always_comb begin
      q_ext_p0     = {1'b0, Q};
      d_ext_p0     = {1'b0, D};
      sum_p0       = q_ext_p0;
      q_next_p0    = Q;
      rco_next_p0  = 1'b0;
      lerr_next_p0 = 1'b0;

      // An illegal (out-of-range) count behaves as the terminal value.
      if (q_ext_p0 > MAX_W) begin
         q_ext_p0 = MAX_W;
      end

      if (ENB) begin
         case (MODO)
            MODO_UP: begin
               if (q_ext_p0 == MAX_W) begin
                  sum_p0      = '0;
                  rco_next_p0 = 1'b1;
               end else begin
                  sum_p0 = q_ext_p0 + ONE_W;
               end
               q_next_p0 = BITS'(sum_p0);
            end
            MODO_DOWN: begin
               if (q_ext_p0 == '0) begin
                  sum_p0      = MAX_W;
                  rco_next_p0 = 1'b1;
               end else begin
                  sum_p0 = q_ext_p0 - ONE_W;
               end
               q_next_p0 = BITS'(sum_p0);
            end
            MODO_STEP: begin
               if (q_ext_p0 >= STEP_W) begin
                  sum_p0 = q_ext_p0 - STEP_W;
               end else begin
                  sum_p0      = q_ext_p0 + MOD_W - STEP_W;
                  rco_next_p0 = 1'b1;
               end
               q_next_p0 = BITS'(sum_p0);
            end
            MODO_LOAD: begin
               if (d_ext_p0 <= MAX_W) begin
                  sum_p0 = d_ext_p0;
               end else begin
                  sum_p0       = MAX_W;
                  lerr_next_p0 = 1'b1;
               end
               q_next_p0 = BITS'(sum_p0);
            end
            default: begin
               q_next_p0 = Q;
            end
         endcase
      end
   end

   // Stage boundary: count and pulse registers.
   dff_nbits_rst #(.N(BITS)) u_q_reg (
      .clk (CLK),
      .rst (RESET),
      .en  (ENB),
      .d   (q_next_p0),
      .q   (Q)
   );

   dff_nbits_rst #(.N(2)) u_pulse_reg (
      .clk (CLK),
      .rst (RESET),
      .en  (1'b1),
      .d   ({rco_next_p0, lerr_next_p0}),
      .q   (pulse_q_p1)
   );

   assign RCO      = pulse_q_p1[1];
   assign LOAD_ERR = pulse_q_p1[0];

   always @(posedge CLK) begin
      if (!RESET && ENB) begin
         assert (!$isunknown(MODO))
         else $error("contador_mod_n: MODO is X/Z while enabled");
      end
   end

endmodule
